// File: rtl/sdram_arbiter.sv
// Round-robin arbiter that funnels several request ports onto one SDRAM controller
// port and routes in-order read returns back to their requesters through a tag FIFO.
module sdram_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 26,
    parameter int DEPTH     = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_PORTS-1:0]        p_req,
    input  logic [NUM_PORTS-1:0]        p_write,
    input  logic [NUM_PORTS*ADDR_W-1:0] p_addr,
    input  logic [NUM_PORTS*32-1:0]     p_wdata,
    input  logic [NUM_PORTS*4-1:0]      p_wmask,
    output logic [NUM_PORTS-1:0]        p_ack,
    output logic [NUM_PORTS-1:0]        p_rvalid,
    output logic [31:0]                 p_rdata,
    output logic                        m_req,
    output logic                        m_write,
    output logic [ADDR_W-1:0]           m_addr,
    output logic [31:0]                 m_wdata,
    output logic [3:0]                  m_wmask,
    input  logic                        m_ready,
    input  logic                        m_rvalid,
    input  logic [31:0]                 m_rdata,
    output logic                        err
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       grant_q, grant_d;
    logic [PW-1:0]       lastGrant_q, lastGrant_d;
    logic                mWrite_q;
    logic [ADDR_W-1:0]   mAddr_q;
    logic [31:0]         mWdata_q;
    logic [3:0]          mWmask_q;

    logic [PW-1:0]       tags_q [DEPTH];
    logic [AW-1:0]       wrPtr_q, rdPtr_q;
    logic [CW-1:0]       count_q;
    logic [NUM_PORTS-1:0] pRvalid_q;
    logic [31:0]         pRdata_q;
    logic                err_q;

    logic [ADDR_W-1:0]   addrArr  [NUM_PORTS];
    logic [31:0]         wdataArr [NUM_PORTS];
    logic [3:0]          wmaskArr [NUM_PORTS];

    logic                found, load, accept, push, pop, fifoFull;
    logic [PW-1:0]       pick;
    logic [PW:0]         sum;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign addrArr[i]  = p_addr[i*ADDR_W +: ADDR_W];
        assign wdataArr[i] = p_wdata[i*32 +: 32];
        assign wmaskArr[i] = p_wmask[i*4 +: 4];
    end

    assign fifoFull = (count_q == CW'(DEPTH));
    assign accept   = (state_q == ISSUE) && m_ready;
    assign push     = accept && !mWrite_q;
    assign pop      = m_rvalid && (count_q != '0);

    // Scan ports starting just after the last winner; reads are skipped while the FIFO is full.
    always_comb begin
        found = 1'b0;
        pick  = lastGrant_q;
        sum   = '0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            sum = {1'b0, lastGrant_q} + (PW+1)'(off);
            if (sum >= (PW+1)'(NUM_PORTS)) sum = sum - (PW+1)'(NUM_PORTS);
            if (!found && p_req[sum[PW-1:0]] && (p_write[sum[PW-1:0]] || !fifoFull)) begin
                found = 1'b1;
                pick  = sum[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ISSUE;
                    grant_d = pick;
                    load    = 1'b1;
                end
            end
            ISSUE: begin
                if (m_ready) begin
                    state_d     = IDLE;
                    lastGrant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        p_ack = '0;
        if (accept) p_ack[grant_q] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            lastGrant_q <= PW'(NUM_PORTS - 1);
            mWrite_q    <= 1'b0;
            mAddr_q     <= '0;
            mWdata_q    <= '0;
            mWmask_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            if (load) begin
                mWrite_q <= p_write[pick];
                mAddr_q  <= addrArr[pick];
                mWdata_q <= wdataArr[pick];
                mWmask_q <= wmaskArr[pick];
            end
        end
    end

    // Tag storage needs no reset: only the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push) tags_q[wrPtr_q] <= grant_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            pRvalid_q <= '0;
            pRdata_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            pRvalid_q <= '0;
            count_q   <= count_q + CW'(push) - CW'(pop);
            if (push) wrPtr_q <= wrPtr_q + AW'(1);
            if (pop) begin
                rdPtr_q                   <= rdPtr_q + AW'(1);
                pRdata_q                  <= m_rdata;
                pRvalid_q[tags_q[rdPtr_q]] <= 1'b1;
            end
            if (m_rvalid && (count_q == '0)) err_q <= 1'b1;
        end
    end

    assign m_req    = (state_q == ISSUE);
    assign m_write  = mWrite_q;
    assign m_addr   = mAddr_q;
    assign m_wdata  = mWdata_q;
    assign m_wmask  = mWmask_q;
    assign p_rvalid = pRvalid_q;
    assign p_rdata  = pRdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed testbench for sdram_arbiter: single read, fairness, backpressure,
// full tag FIFO, return ordering with the empty-return error, and mid-operation reset.
module tb_sdram_arbiter;

    localparam int NP  = 4;
    localparam int AWD = 26;

    logic              clock = 1'b0;
    logic              resetN;
    logic [NP-1:0]     pReq, pWrite;
    logic [NP*AWD-1:0] pAddr;
    logic [NP*32-1:0]  pWdata;
    logic [NP*4-1:0]   pWmask;
    logic [NP-1:0]     pAck, pRvalid;
    logic [31:0]       pRdata;
    logic              mReq, mWrite;
    logic [AWD-1:0]    mAddr;
    logic [31:0]       mWdata;
    logic [3:0]        mWmask;
    logic              mReady, mRvalid;
    logic [31:0]       mRdata;
    logic              err;

    int checks = 0;
    int passed = 0;

    sdram_arbiter #(.NUM_PORTS(NP), .ADDR_W(AWD), .DEPTH(4)) dut (
        .clock    (clock),
        .reset_n  (resetN),
        .p_req    (pReq),
        .p_write  (pWrite),
        .p_addr   (pAddr),
        .p_wdata  (pWdata),
        .p_wmask  (pWmask),
        .p_ack    (pAck),
        .p_rvalid (pRvalid),
        .p_rdata  (pRdata),
        .m_req    (mReq),
        .m_write  (mWrite),
        .m_addr   (mAddr),
        .m_wdata  (mWdata),
        .m_wmask  (mWmask),
        .m_ready  (mReady),
        .m_rvalid (mRvalid),
        .m_rdata  (mRdata),
        .err      (err)
    );

    always #5 clock = ~clock;

    // Each "slot" starts 1ns after a rising edge; inputs change there, outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic write,
                                 input logic [AWD-1:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wmask);
        pReq[port]              = req;
        pWrite[port]            = write;
        pAddr[port*AWD +: AWD]  = addr;
        pWdata[port*32 +: 32]   = wdata;
        pWmask[port*4 +: 4]     = wmask;
    endtask

    task automatic doReset();
        resetN  = 1'b0;
        pReq    = '0;
        mReady  = 1'b0;
        mRvalid = 1'b0;
        #1;
        tick();
        resetN = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetN = 1'b0;
        pReq = '0; pWrite = '0; pAddr = '0; pWdata = '0; pWmask = '0;
        mReady = 1'b0; mRvalid = 1'b0; mRdata = '0;
        tick();
        tick();

        checkOutput("rst_m_req",    64'(mReq), 64'(0));
        checkOutput("rst_p_ack",    64'(pAck), 64'(0));
        checkOutput("rst_p_rvalid", 64'(pRvalid), 64'(0));
        checkOutput("rst_p_rdata",  64'(pRdata), 64'(0));
        checkOutput("rst_err",      64'(err), 64'(0));
        checkOutput("rst_m_fields", 64'({mWrite, mAddr, mWdata, mWmask}), 64'(0));
        resetN = 1'b1;

        // Single read from port 0
        applyStimulus(0, 1'b1, 1'b0, 26'h100, 32'h0, 4'hF);
        mReady = 1'b1;
        #1;
        checkOutput("rd_mreq_before", 64'(mReq), 64'(0));
        tick();
        checkOutput("rd_mreq", 64'(mReq), 64'(1));
        checkOutput("rd_fields", 64'({mWrite, mAddr, mWdata, mWmask}), 64'({1'b0, 26'h100, 32'h0, 4'hF}));
        checkOutput("rd_ack", 64'(pAck), 64'(4'b0001));
        tick();
        applyStimulus(0, 1'b0, 1'b0, 26'h100, 32'h0, 4'hF);
        #1;
        checkOutput("rd_idle", 64'({mReq, pAck}), 64'(0));
        tick();
        tick();
        mRvalid = 1'b1;
        mRdata  = 32'hDEADBEEF;
        #1;
        checkOutput("rd_rvalid_early", 64'(pRvalid), 64'(0));
        tick();
        mRvalid = 1'b0;
        #1;
        checkOutput("rd_rvalid", 64'(pRvalid), 64'(4'b0001));
        checkOutput("rd_rdata", 64'(pRdata), 64'(32'hDEADBEEF));
        tick();
        checkOutput("rd_rvalid_pulse", 64'(pRvalid), 64'(0));
        checkOutput("rd_err", 64'(err), 64'(0));

        // Fairness: all four ports write continuously
        doReset();
        for (int i = 0; i < NP; i++)
            applyStimulus(i, 1'b1, 1'b1, 26'h1000 + 26'(i), 32'hA0 + 32'(i), 4'hF);
        mReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("fair_ack%0d", k), 64'(pAck), 64'(1 << (k % 4)));
            checkOutput($sformatf("fair_addr%0d", k), 64'(mAddr), 64'(26'h1000 + 26'(k % 4)));
            tick();
            if (k == 4) pReq = '0;
            #1;
            checkOutput($sformatf("fair_gap%0d", k), 64'(pAck), 64'(0));
        end

        // Backpressure: m_ready low for 5 cycles in ISSUE
        doReset();
        applyStimulus(3, 1'b1, 1'b1, 26'h2AA, 32'hCAFEF00D, 4'hA);
        mReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("bp_fields%0d", k), 64'({mReq, mWrite, mAddr, mWdata, mWmask}),
                        64'({1'b1, 1'b1, 26'h2AA, 32'hCAFEF00D, 4'hA}));
            checkOutput($sformatf("bp_noack%0d", k), 64'(pAck), 64'(0));
        end
        tick();
        mReady = 1'b1;
        #1;
        checkOutput("bp_ack", 64'(pAck), 64'(4'b1000));
        tick();
        applyStimulus(3, 1'b0, 1'b1, 26'h2AA, 32'hCAFEF00D, 4'hA);
        #1;
        checkOutput("bp_done", 64'({mReq, pAck}), 64'(0));

        // Full FIFO: four reads outstanding, then a read and a write compete
        doReset();
        mReady = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 26'h300, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("fill_ack%0d", k), 64'(pAck), 64'(4'b0001));
            tick();
        end
        applyStimulus(0, 1'b0, 1'b0, 26'h300, 32'h0, 4'hF);
        applyStimulus(1, 1'b1, 1'b0, 26'h311, 32'h0, 4'hF);
        applyStimulus(2, 1'b1, 1'b1, 26'h322, 32'h22222222, 4'h3);
        tick();
        checkOutput("full_write_ack", 64'(pAck), 64'(4'b0100));
        checkOutput("full_write_addr", 64'(mAddr), 64'(26'h322));
        tick();
        applyStimulus(2, 1'b0, 1'b1, 26'h322, 32'h22222222, 4'h3);
        #1;
        checkOutput("full_stall0", 64'(mReq), 64'(0));
        tick();
        checkOutput("full_stall1", 64'(mReq), 64'(0));
        mRvalid = 1'b1;
        mRdata  = 32'h11111111;
        tick();
        mRvalid = 1'b0;
        #1;
        checkOutput("full_pop_rvalid", 64'(pRvalid), 64'(4'b0001));
        checkOutput("full_pop_mreq", 64'(mReq), 64'(0));
        tick();
        checkOutput("full_read_mreq", 64'(mReq), 64'(1));
        checkOutput("full_read_addr", 64'(mAddr), 64'(26'h311));
        checkOutput("full_read_ack", 64'(pAck), 64'(4'b0010));
        tick();
        applyStimulus(1, 1'b0, 1'b0, 26'h311, 32'h0, 4'hF);

        // Ordering: reads from port 2 then port 0, then one return too many
        doReset();
        mReady = 1'b1;
        applyStimulus(2, 1'b1, 1'b0, 26'h400, 32'h0, 4'hF);
        tick();
        checkOutput("ord_ack2", 64'(pAck), 64'(4'b0100));
        tick();
        applyStimulus(2, 1'b0, 1'b0, 26'h400, 32'h0, 4'hF);
        applyStimulus(0, 1'b1, 1'b0, 26'h404, 32'h0, 4'hF);
        tick();
        checkOutput("ord_ack0", 64'(pAck), 64'(4'b0001));
        tick();
        applyStimulus(0, 1'b0, 1'b0, 26'h404, 32'h0, 4'hF);
        mRvalid = 1'b1;
        mRdata  = 32'hAAAA0002;
        tick();
        mRdata = 32'h0000BBBB;
        #1;
        checkOutput("ord_first_port", 64'(pRvalid), 64'(4'b0100));
        checkOutput("ord_first_data", 64'(pRdata), 64'(32'hAAAA0002));
        tick();
        mRdata = 32'h33333333;
        #1;
        checkOutput("ord_second_port", 64'(pRvalid), 64'(4'b0001));
        checkOutput("ord_second_data", 64'(pRdata), 64'(32'h0000BBBB));
        checkOutput("ord_err_clear", 64'(err), 64'(0));
        tick();
        mRvalid = 1'b0;
        #1;
        checkOutput("ord_extra_norvalid", 64'(pRvalid), 64'(0));
        checkOutput("ord_extra_dropped", 64'(pRdata), 64'(32'h0000BBBB));
        checkOutput("ord_err_set", 64'(err), 64'(1));
        tick();
        checkOutput("ord_err_sticky", 64'(err), 64'(1));

        // Reset in ISSUE with two reads outstanding (continues from the error state above)
        applyStimulus(1, 1'b1, 1'b0, 26'h500, 32'h0, 4'hF);
        tick();
        checkOutput("mid_ack1", 64'(pAck), 64'(4'b0010));
        tick();
        applyStimulus(1, 1'b0, 1'b0, 26'h500, 32'h0, 4'hF);
        applyStimulus(3, 1'b1, 1'b0, 26'h503, 32'h0, 4'hF);
        tick();
        checkOutput("mid_ack3", 64'(pAck), 64'(4'b1000));
        tick();
        applyStimulus(3, 1'b0, 1'b0, 26'h503, 32'h0, 4'hF);
        applyStimulus(2, 1'b1, 1'b1, 26'h502, 32'h5, 4'hF);
        mReady = 1'b0;
        tick();
        checkOutput("mid_issue", 64'(mReq), 64'(1));
        #1;
        resetN = 1'b0;
        mReady = 1'b1;
        #1;
        checkOutput("mid_mreq_drop", 64'(mReq), 64'(0));
        checkOutput("mid_ack_low", 64'(pAck), 64'(0));
        checkOutput("mid_err_clear", 64'(err), 64'(0));
        checkOutput("mid_rdata_clear", 64'(pRdata), 64'(0));
        tick();
        tick();
        for (int i = 0; i < NP; i++)
            applyStimulus(i, 1'b1, 1'b1, 26'h600 + 26'(i), 32'h0, 4'hF);
        resetN = 1'b1;
        tick();
        checkOutput("mid_first_grant", 64'(pAck), 64'(4'b0001));
        checkOutput("mid_first_addr", 64'(mAddr), 64'(26'h600));
        tick();
        pReq    = '0;
        mRvalid = 1'b1;
        mRdata  = 32'h77777777;
        tick();
        mRvalid = 1'b0;
        #1;
        checkOutput("mid_fifo_empty_rvalid", 64'(pRvalid), 64'(0));
        checkOutput("mid_fifo_empty_err", 64'(err), 64'(1));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, giving the number of requesting ports (legal range 2..8).
REQ-002 The block SHALL have parameter ADDR_W, default 26, giving the byte-address width.
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the number of outstanding reads (power of two, 2..16).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, named as the ports below:
  clock      in   1                 system clock; all state changes on its rising edge
  reset_n    in   1                 asynchronous, active-low reset
  p_req      in   NUM_PORTS         per-port request; held high until p_ack
  p_write    in   NUM_PORTS         per-port: 1 = write, 0 = read
  p_addr     in   NUM_PORTS*ADDR_W  per-port address; port i occupies slice i
  p_wdata    in   NUM_PORTS*32      per-port write data
  p_wmask    in   NUM_PORTS*4       per-port byte enables
  p_ack      out  NUM_PORTS         one-cycle pulse: the port's request was accepted downstream
  p_rvalid   out  NUM_PORTS         one-cycle pulse: p_rdata holds this port's read data
  p_rdata    out  32                shared read data
  m_req      out  1                 request to the SDRAM controller
  m_write, m_addr, m_wdata, m_wmask  out  1/ADDR_W/32/4  fields of the request
  m_ready    in   1                 controller accepts the request when m_req and m_ready are both high
  m_rvalid   in   1                 controller returns read data; returns are in request order
  m_rdata    in   32                returned read data
  err        out  1                 sticky protocol-error flag

Function
REQ-005 The block SHALL be a two-state FSM with states IDLE and ISSUE.
REQ-006 In IDLE, the block SHALL grant the eligible port that comes first in round-robin order, starting at (last_grant+1) mod NUM_PORTS.
REQ-007 A port SHALL be eligible when its p_req is high and it is either a write, or a read while the tag FIFO is not full.
REQ-008 On a grant, the block SHALL register that port's fields onto m_* and go to ISSUE, so m_req rises one cycle after p_req is sampled.
REQ-009 In ISSUE, m_req SHALL stay high and all m_* fields SHALL stay stable until the cycle in which m_ready is high.
REQ-010 In that accepting cycle, the block SHALL drive p_ack[grant]=1 combinationally, update last_grant, push the port index into the tag FIFO if the request is a read, and return to IDLE with m_req=0 on the next cycle.
REQ-011 Maximum throughput SHALL be one accepted request every 2 cycles.
REQ-012 The tag FIFO SHALL use DEPTH entries with a count of width clog2(DEPTH)+1; pointers SHALL wrap modulo DEPTH.
REQ-013 On m_rvalid with the FIFO non-empty, the block SHALL pop the head tag, register p_rdata<=m_rdata, and pulse p_rvalid[head]=1 for one cycle (latency 1).
REQ-014 If a push and a pop occur in the same cycle, both SHALL take effect and the count SHALL be unchanged; this SHALL also hold when the FIFO is full.
REQ-015 On m_rvalid with the FIFO empty, the block SHALL drop the data, keep p_rvalid low, and set err=1; err SHALL stay set until reset.
REQ-016 While the FIFO is full, reads SHALL be skipped in arbitration (round robin proceeds to the next eligible port); writes SHALL still be granted.
REQ-017 At most one bit of p_ack and at most one bit of p_rvalid SHALL be high in any cycle.

Reset
REQ-018 While reset_n=0, the block SHALL force, asynchronously: state=IDLE, m_req=0, all m_* fields=0, p_ack=0, p_rvalid=0, p_rdata=0, err=0, FIFO empty, last_grant=NUM_PORTS-1 (so port 0 wins first).
REQ-019 If reset is asserted during ISSUE or with reads outstanding, the block SHALL discard the in-flight state; m_req SHALL fall in the same instant as reset_n.
REQ-020 The block SHALL leave reset on the first rising edge of clock with reset_n=1.

Verification
REQ-021 Single read: port0 reads 0x100 with m_ready=1, then m_rvalid with m_rdata=0xDEADBEEF 3 cycles later -> m_req high 1 cycle after p_req, p_ack[0] pulses, p_rvalid[0]=1 with p_rdata=0xDEADBEEF one cycle after m_rvalid.
REQ-022 Fairness: all 4 ports request continuously after reset -> grants in order 0,1,2,3,0, one every 2 cycles.
REQ-023 Backpressure: m_ready held low for 5 cycles during ISSUE -> m_* stable for all 5 cycles, exactly one p_ack pulse when m_ready rises.
REQ-024 Full FIFO: DEPTH=4 reads outstanding, port1 requests a read and port2 a write -> port2 granted, port1 stalls; port1 is granted in the cycle after the next m_rvalid.
REQ-025 Ordering and error: reads from ports 2 then 0, two m_rvalid returns -> p_rvalid[2] then p_rvalid[0]; a third m_rvalid -> err=1, no p_rvalid pulse.
REQ-026 Reset mid-operation: reset_n=0 in ISSUE with 2 reads outstanding -> m_req=0 immediately; after release the first grant goes to port 0 and the FIFO is empty.
